crc_holdback_fifo: RTL and testbench

Packet-aware receive FIFO for the USB receiver datapath. It buffers the data-packet byte stream, strips the trailing CRC bytes (HOLD of them, 2 for CRC16), and presents them separately for checking. Only whole packets that have been committed are visible to the reader, and it drops aborted or overflowed packets. It supersedes the fixed 8-bit, 64-deep CRC padding FIFO with parametrised width, depth and trailer length, plus packet commit/abort semantics.

---
 rtl/crc_holdback_fifo_if.sv | 35 +++
 rtl/crc_holdback_fifo.sv | 184 ++++++++++++++++++
 tb/tb_crc_holdback_fifo.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_holdback_fifo_if.sv
// Bus bundle for crc_holdback_fifo: packet write port, show-ahead read port and the
// stripped CRC trailer with its status pulses.
interface crc_holdback_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned HOLD   = 2
) ();
    logic                     w_enable;
    logic [DATA_W-1:0]        w_data;
    logic                     w_eop;
    logic                     w_abort;
    logic                     r_enable;
    logic [DATA_W-1:0]        r_data;
    logic                     r_last;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic [ADDR_W:0]          count;
    logic [HOLD*DATA_W-1:0]   crc_tail;
    logic                     crc_valid;
    logic                     runt;
    logic                     overflow;

    modport master (
        output w_enable, w_data, w_eop, w_abort, r_enable,
        input  r_data, r_last, empty, full, almost_full, count,
        input  crc_tail, crc_valid, runt, overflow
    );

    modport slave (
        input  w_enable, w_data, w_eop, w_abort, r_enable,
        output r_data, r_last, empty, full, almost_full, count,
        output crc_tail, crc_valid, runt, overflow
    );
endinterface

// File: rtl/crc_holdback_fifo.sv
// Packet-aware receive FIFO: buffers a packet, strips its trailing HOLD words into crc_tail
// and only exposes whole committed packets to the reader; aborted/overflowed packets vanish.
module crc_holdback_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned HOLD      = 2,
    parameter int unsigned AFULL_LVL = 56
) (
    input logic                clk,
    input logic                n_rst,
    crc_holdback_fifo_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned TAIL_W = HOLD * DATA_W;
    localparam int unsigned LEN_W  = 3;

    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t              HOLD_P  = ptr_t'(HOLD);
    localparam ptr_t              DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t              AFULL_P = ptr_t'(AFULL_LVL);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(HOLD + 1);
    localparam logic [LEN_W-1:0]  HOLD_L  = LEN_W'(HOLD);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(HOLD + 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic              last_q [DEPTH];

    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              cm_ptr_q, cm_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              ovf_pend_q, ovf_pend_d;

    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              almost_full_q, almost_full_d;
    ptr_t              count_q, count_d;
    logic [TAIL_W-1:0] crc_tail_q, crc_tail_d;
    logic              crc_valid_q, crc_valid_d;
    logic              runt_q, runt_d;
    logic              overflow_q, overflow_d;

    logic              wr_accept;
    logic              wr_drop;
    logic              rd_accept;
    logic              eop;
    logic              commit;
    ptr_t              wr_post;
    ptr_t              occ_d;
    logic [LEN_W-1:0]  len_post;
    logic [TAIL_W-1:0] tail_shift;
    logic [TAIL_W-1:0] tail_post;
    logic              ovf_post;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] last_idx;

    if (HOLD == 1) begin : g_tail_one
        assign tail_shift = bus.w_data;
    end else begin : g_tail_multi
        assign tail_shift = {tail_q[TAIL_W-DATA_W-1:0], bus.w_data};
    end

    always_comb begin
        wr_accept = bus.w_enable & ~full_q & ~bus.w_abort;
        wr_drop   = bus.w_enable & full_q & ~bus.w_abort;
        rd_accept = bus.r_enable & ~empty_q;
        eop       = bus.w_eop & ~bus.w_abort;

        // A word written alongside w_eop belongs to the packet being closed.
        wr_post   = wr_ptr_q + ptr_t'(wr_accept);
        len_post  = (wr_accept && pkt_len_q != LEN_MAX) ? pkt_len_q + LEN_W'(1) : pkt_len_q;
        tail_post = wr_accept ? tail_shift : tail_q;
        ovf_post  = ovf_pend_q | wr_drop;
        commit    = eop & ~ovf_post & (len_post > HOLD_L);

        wr_idx    = wr_ptr_q[ADDR_W-1:0];
        rd_idx    = rd_ptr_q[ADDR_W-1:0];
        last_idx  = wr_post[ADDR_W-1:0] - LAST_A;
    end

    always_comb begin
        wr_ptr_d    = wr_post;
        cm_ptr_d    = cm_ptr_q;
        rd_ptr_d    = rd_ptr_q + ptr_t'(rd_accept);
        pkt_len_d   = len_post;
        tail_d      = tail_post;
        ovf_pend_d  = ovf_post;
        crc_tail_d  = crc_tail_q;
        crc_valid_d = 1'b0;
        runt_d      = 1'b0;
        overflow_d  = 1'b0;

        if (bus.w_abort) begin
            wr_ptr_d   = cm_ptr_q;
            pkt_len_d  = '0;
            tail_d     = '0;
            ovf_pend_d = 1'b0;
        end else if (eop) begin
            pkt_len_d  = '0;
            tail_d     = '0;
            ovf_pend_d = 1'b0;
            if (ovf_post) begin
                wr_ptr_d   = cm_ptr_q;
                overflow_d = 1'b1;
            end else if (commit) begin
                wr_ptr_d    = wr_post - HOLD_P;
                cm_ptr_d    = wr_post - HOLD_P;
                crc_tail_d  = tail_post;
                crc_valid_d = 1'b1;
            end else begin
                wr_ptr_d    = cm_ptr_q;
                crc_tail_d  = tail_post;
                crc_valid_d = 1'b1;
                runt_d      = 1'b1;
            end
        end

        // Status flags track the next pointers so they carry no extra cycle of lag.
        occ_d         = wr_ptr_d - rd_ptr_d;
        full_d        = (occ_d == DEPTH_P);
        almost_full_d = (occ_d >= AFULL_P);
        count_d       = cm_ptr_d - rd_ptr_d;
        empty_d       = (cm_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q      <= '0;
            cm_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pkt_len_q     <= '0;
            tail_q        <= '0;
            ovf_pend_q    <= 1'b0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            count_q       <= '0;
            crc_tail_q    <= '0;
            crc_valid_q   <= 1'b0;
            runt_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            cm_ptr_q      <= cm_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pkt_len_q     <= pkt_len_d;
            tail_q        <= tail_d;
            ovf_pend_q    <= ovf_pend_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            count_q       <= count_d;
            crc_tail_q    <= crc_tail_d;
            crc_valid_q   <= crc_valid_d;
            runt_q        <= runt_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: every committed word and its flag are rewritten in-packet.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            data_q[wr_idx] <= bus.w_data;
            last_q[wr_idx] <= 1'b0;
        end
        if (commit) begin
            last_q[last_idx] <= 1'b1;
        end
    end

    assign bus.r_data      = data_q[rd_idx];
    assign bus.r_last      = last_q[rd_idx] & ~empty_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.count       = count_q;
    assign bus.crc_tail    = crc_tail_q;
    assign bus.crc_valid   = crc_valid_q;
    assign bus.runt        = runt_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_crc_holdback_fifo.sv
// Randomized and directed bench for crc_holdback_fifo against a queue-based packet model.
module tb_crc_holdback_fifo;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 6;
    localparam int HOLD      = 2;
    localparam int AFULL_LVL = 56;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int TAIL_W    = HOLD * DATA_W;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    crc_holdback_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD(HOLD)) bus ();

    crc_holdback_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .HOLD     (HOLD),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                last;
    } ent_t;

    ent_t              cq[$];
    logic [DATA_W-1:0] pk[$];
    bit                m_ovf;
    logic [TAIL_W-1:0] m_tail;
    bit                m_valid, m_runt, m_over;
    int                checks = 0;
    int                failures = 0;
    int                pops = 0;
    int                last_pops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int occ;
        bit full_m;
        bit was_empty;
        logic [TAIL_W-1:0] t;
        occ = cq.size() + pk.size();
        full_m = (occ == DEPTH);
        was_empty = (cq.size() == 0);
        m_valid = 0;
        m_runt = 0;
        m_over = 0;
        if (n_rst) begin
            cq.delete();
            pk.delete();
            m_ovf = 0;
            m_tail = '0;
            return;
        end
        if (bus.r_enable && !was_empty) begin
            pops++;
            if (cq[0].last) last_pops++;
            void'(cq.pop_front());
        end
        if (bus.w_abort) begin
            pk.delete();
            m_ovf = 0;
            return;
        end
        if (bus.w_enable) begin
            if (!full_m) pk.push_back(bus.w_data);
            else m_ovf = 1;
        end
        if (bus.w_eop) begin
            t = '0;
            for (int i = 0; i < HOLD; i++)
                if (pk.size() > i) t[i*DATA_W +: DATA_W] = pk[pk.size()-1-i];
            if (m_ovf) begin
                m_over = 1;
            end else begin
                m_tail = t;
                m_valid = 1;
                if (pk.size() > HOLD) begin
                    for (int i = 0; i < pk.size() - HOLD; i++) begin
                        ent_t e;
                        e.d = pk[i];
                        e.last = (i == pk.size() - HOLD - 1);
                        cq.push_back(e);
                    end
                end else begin
                    m_runt = 1;
                end
            end
            pk.delete();
            m_ovf = 0;
        end
    endtask

    task automatic compare();
        int occ;
        occ = cq.size() + pk.size();
        chk("empty", bus.empty, cq.size() == 0);
        chk("count", bus.count, cq.size());
        chk("full", bus.full, occ == DEPTH);
        chk("almost_full", bus.almost_full, occ >= AFULL_LVL);
        chk("crc_tail", bus.crc_tail, m_tail);
        chk("crc_valid", bus.crc_valid, m_valid);
        chk("runt", bus.runt, m_runt);
        chk("overflow", bus.overflow, m_over);
        if (cq.size() > 0) begin
            chk("r_data", bus.r_data, cq[0].d);
            chk("r_last", bus.r_last, cq[0].last);
        end
    endtask

    task automatic drive(input bit we, input logic [DATA_W-1:0] wd, input bit eop,
                         input bit ab, input bit re, input bit rst);
        bus.w_enable = we;
        bus.w_data   = wd;
        bus.w_eop    = eop;
        bus.w_abort  = ab;
        bus.r_enable = re;
        n_rst        = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        drive(1, d, 0, 0, 0, 0);
    endtask

    task automatic eop();
        drive(0, '0, 1, 0, 0, 0);
    endtask

    task automatic rd();
        drive(0, '0, 0, 0, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_enable = 0;
        bus.w_data   = '0;
        bus.w_eop    = 0;
        bus.w_abort  = 0;
        bus.r_enable = 0;
        drive(0, '0, 0, 0, 0, 1);
        drive(0, '0, 0, 0, 0, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_afull", bus.almost_full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_tail", bus.crc_tail, 0);
        chk("rst_pulses", {bus.crc_valid, bus.runt, bus.overflow}, 0);
        chk("rst_r_last", bus.r_last, 0);

        // Basic packet with stripped CRC16.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'hA5); wr(8'h5A);
        eop();
        chk("t1_valid", bus.crc_valid, 1);
        chk("t1_tail", bus.crc_tail, 16'hA55A);
        chk("t1_count", bus.count, 3);
        chk("t1_d0", {bus.r_data, bus.r_last}, {8'h11, 1'b0});
        rd();
        chk("t1_pulse_width", bus.crc_valid, 0);
        chk("t1_d1", {bus.r_data, bus.r_last}, {8'h22, 1'b0});
        rd();
        chk("t1_d2", {bus.r_data, bus.r_last}, {8'h33, 1'b1});
        rd();
        chk("t1_empty", bus.empty, 1);

        // Abort discards the partial packet.
        wr(8'h01); wr(8'h02); wr(8'h03);
        drive(0, '0, 0, 1, 0, 0);
        wr(8'h44); wr(8'h55); wr(8'h66); wr(8'h77);
        eop();
        chk("t2_count", bus.count, 2);
        chk("t2_tail", bus.crc_tail, 16'h6677);
        chk("t2_d0", {bus.r_data, bus.r_last}, {8'h44, 1'b0});
        rd();
        chk("t2_d1", {bus.r_data, bus.r_last}, {8'h55, 1'b1});
        rd();

        // Word and eop in the same cycle.
        wr(8'hAA); wr(8'hBB); wr(8'hCC);
        drive(1, 8'hC3, 1, 0, 0, 0);
        chk("t3_tail", bus.crc_tail, 16'hCCC3);
        chk("t3_count", bus.count, 2);
        chk("t3_d0", {bus.r_data, bus.r_last}, {8'hAA, 1'b0});
        rd();
        chk("t3_d1", {bus.r_data, bus.r_last}, {8'hBB, 1'b1});
        rd();

        // Runt packet.
        wr(8'h12); wr(8'h34);
        eop();
        chk("t4_runt", bus.runt, 1);
        chk("t4_valid", bus.crc_valid, 1);
        chk("t4_count", bus.count, 0);
        chk("t4_tail", bus.crc_tail, 16'h1234);

        // Overflow: 70 words into 64 entries.
        for (int i = 0; i < 64; i++) begin
            wr(DATA_W'(i));
            if (i == 54) chk("t5_afull_55", bus.almost_full, 0);
            if (i == 55) chk("t5_afull_56", bus.almost_full, 1);
        end
        chk("t5_full", bus.full, 1);
        for (int i = 0; i < 6; i++) wr(8'hEE);
        eop();
        chk("t5_overflow", bus.overflow, 1);
        chk("t5_no_valid", bus.crc_valid, 0);
        chk("t5_count", bus.count, 0);
        chk("t5_full_clr", bus.full, 0);
        chk("t5_tail_held", bus.crc_tail, 16'h1234);
        wr(8'h60); wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
        eop();
        chk("t5_next_count", bus.count, 3);
        chk("t5_next_tail", bus.crc_tail, 16'h6364);
        rd(); rd(); rd();

        // Pointer wrap with concurrent reads.
        pops = 0;
        last_pops = 0;
        for (int p = 0; p < 10; p++) begin
            for (int w = 0; w < 30; w++) drive(1, DATA_W'($urandom), 0, 0, 1, 0);
            drive(0, '0, 1, 0, 1, 0);
        end
        for (int i = 0; i < 100 && bus.empty !== 1'b1; i++) rd();
        chk("t6_drained", bus.empty, 1);
        chk("t6_pops", pops, 280);
        chk("t6_lasts", last_pops, 10);

        // Random traffic, alternating read-heavy and fill-heavy phases.
        for (int i = 0; i < 4000; i++) begin
            int rdp;
            rdp = ((i / 500) % 2 == 1) ? 10 : 70;
            drive($urandom_range(99) < 60, DATA_W'($urandom),
                  $urandom_range(99) < ((i / 500) % 2 == 1 ? 2 : 7),
                  $urandom_range(199) < 2, $urandom_range(99) < rdp,
                  $urandom_range(999) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
